// File: rtl/tri_serializer.sv
// tri_serializer: transmit side of the rasterizer triangle input link.
// Buffers whole triangles (NWORDS x WORD_W bits) in a small circular FIFO,
// shifts each one out MSB-first on D and waits for the DONE pulse before
// starting the next triangle.
// Optional build macro: DONE_TIMEOUT_EN adds a DONE watchdog that sets a sticky
// TIMEOUT flag and releases the FSM after TIMEOUT_CYCLES cycles in WAIT_DONE.
module tri_serializer #(
    parameter int WORD_W         = 16,
    parameter int NWORDS         = 9,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WORD_W*NWORDS-1:0] TRI_IN,
    input  logic                     TRI_VALID,
    output logic                     TRI_READY,
    output logic                     D,
    output logic                     D_FRAME,
    input  logic                     DONE,
    output logic                     BUSY,
    output logic [15:0]              TRI_COUNT,
    output logic                     TIMEOUT
);

    localparam int TOTAL_W = WORD_W * NWORDS;
    localparam int BIT_W   = $clog2(TOTAL_W);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOTAL_W - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_n_s;

    logic [TOTAL_W-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_n_s;
    logic [TOTAL_W-1:0]   head_s;

    logic [TOTAL_W-1:0]   sr_r;
    logic [BIT_W-1:0]     bit_cnt_r;

    logic                 push_s;
    logic                 pop_s;
    logic                 done_ack_s;

`ifdef DONE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ZERO = WD_W'(0);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0]      wd_cnt_r;
    logic                 wd_expire_s;
`else
    logic                 unused_cfg_s;
    assign unused_cfg_s = (TIMEOUT_CYCLES != 32'sd0);
`endif

    // Ready is withheld during reset so nothing can be pushed into a FIFO being cleared.
    assign TRI_READY = !RST && (count_r < DEPTH_C);
    assign push_s    = TRI_VALID && TRI_READY;
    assign head_s    = mem_r[rd_ptr_r];

    // Next-state decode: pops only from IDLE with data, DONE only honoured in WAIT_DONE.
    always_comb begin
        state_n_s   = state_r;
        pop_s       = 1'b0;
        done_ack_s  = 1'b0;
`ifdef DONE_TIMEOUT_EN
        wd_expire_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (count_r != CNT_ZERO) begin
                    pop_s     = 1'b1;
                    state_n_s = SHIFT;
                end else begin
                    state_n_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_cnt_r == BIT_ZERO) begin
                    state_n_s = WAIT_DONE;
                end else begin
                    state_n_s = SHIFT;
                end
            end
            WAIT_DONE: begin
                if (DONE) begin
                    done_ack_s = 1'b1;
                    state_n_s  = IDLE;
                end
`ifdef DONE_TIMEOUT_EN
                else if (wd_cnt_r == WD_LAST) begin
                    wd_expire_s = 1'b1;
                    state_n_s   = IDLE;
                end
`endif
                else begin
                    state_n_s = WAIT_DONE;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_n_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_n_s = count_r + CNT_ONE;
            2'b01:   count_n_s = count_r - CNT_ONE;
            default: count_n_s = count_r;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_n_s;
        end
    end

    // FIFO storage; push is already blocked during reset so no clear is needed.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= TRI_IN;
        end
    end

    // FSM state, shift register and serial outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            sr_r      <= {TOTAL_W{1'b0}};
            bit_cnt_r <= BIT_ZERO;
            D         <= 1'b0;
            D_FRAME   <= 1'b0;
        end else begin
            state_r <= state_n_s;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        sr_r      <= head_s;
                        bit_cnt_r <= LAST_BIT;
                        D         <= head_s[TOTAL_W-1];
                        D_FRAME   <= 1'b1;
                    end else begin
                        D         <= 1'b0;
                        D_FRAME   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt_r == BIT_ZERO) begin
                        D       <= 1'b0;
                        D_FRAME <= 1'b0;
                    end else begin
                        sr_r      <= {sr_r[TOTAL_W-2:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r - BIT_ONE;
                        D         <= sr_r[TOTAL_W-2];
                        D_FRAME   <= 1'b1;
                    end
                end
                default: begin
                    D       <= 1'b0;
                    D_FRAME <= 1'b0;
                end
            endcase
        end
    end

    // Completed-triangle counter and busy indication from next-cycle state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            TRI_COUNT <= 16'd0;
            BUSY      <= 1'b0;
        end else begin
            if (done_ack_s) begin
                TRI_COUNT <= TRI_COUNT + 16'd1;
            end
            BUSY <= (state_n_s != IDLE) || (count_n_s != CNT_ZERO);
        end
    end

`ifdef DONE_TIMEOUT_EN
    // Watchdog: cleared outside WAIT_DONE, counts each cycle spent waiting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wd_cnt_r <= WD_ZERO;
        end else if (state_r != WAIT_DONE) begin
            wd_cnt_r <= WD_ZERO;
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_ONE;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            TIMEOUT <= 1'b0;
        end else begin
            TIMEOUT <= TIMEOUT | wd_expire_s;
        end
    end
`else
    // Without the watchdog the timeout flag is permanently low.
    always_ff @(posedge CLK) begin
        TIMEOUT <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_tri_serializer.sv
// Self-checking bench for tri_serializer (default build, watchdog disabled).
// A negedge monitor rebuilds each D_FRAME burst into a vector; the stimulus
// block compares those vectors, timings and status outputs to expectations
// derived from the pushed triangles.
module tb_tri_serializer;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [143:0] TRI_IN = 144'd0;
    logic         TRI_VALID = 1'b0;
    logic         TRI_READY;
    logic         D;
    logic         D_FRAME;
    logic         DONE = 1'b0;
    logic         BUSY;
    logic [15:0]  TRI_COUNT;
    logic         TIMEOUT;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Monitor state
    logic         in_frame = 1'b0;
    logic [143:0] cur_bits = 144'd0;
    int           cur_len  = 0;
    int           rise_cyc = 0;
    int           idle_d_bad = 0;
    logic [143:0] rx_bits_q[$];
    int           rx_len_q[$];
    int           rx_rise_q[$];

    tri_serializer dut (
        .CLK       (CLK),
        .RST       (RST),
        .TRI_IN    (TRI_IN),
        .TRI_VALID (TRI_VALID),
        .TRI_READY (TRI_READY),
        .D         (D),
        .D_FRAME   (D_FRAME),
        .DONE      (DONE),
        .BUSY      (BUSY),
        .TRI_COUNT (TRI_COUNT),
        .TIMEOUT   (TIMEOUT)
    );

    // Clock generation
    always #5 CLK = ~CLK;

    // Edge counter: value after edge n equals n
    always @(posedge CLK) cyc <= cyc + 1;

    // Frame reassembly and idle-D watch
    always @(negedge CLK) begin
        if (D_FRAME === 1'b1) begin
            if (!in_frame) begin
                in_frame <= 1'b1;
                rise_cyc <= cyc;
                cur_bits <= {143'd0, D};
                cur_len  <= 1;
            end else begin
                cur_bits <= {cur_bits[142:0], D};
                cur_len  <= cur_len + 1;
            end
        end else begin
            if (D !== 1'b0) idle_d_bad <= idle_d_bad + 1;
            if (in_frame) begin
                in_frame <= 1'b0;
                rx_bits_q.push_back(cur_bits);
                rx_len_q.push_back(cur_len);
                rx_rise_q.push_back(rise_cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [143:0] rand_tri();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[143:0];
    endfunction

    // Offer a triangle and return the edge number where it was accepted
    task automatic push(input logic [143:0] t, output int acc_edge);
        logic rdy;
        int   n;
        TRI_IN    = t;
        TRI_VALID = 1'b1;
        acc_edge  = -1;
        n = 0;
        while (acc_edge < 0 && n < 400) begin
            rdy = TRI_READY;
            @(posedge CLK);
            #1;
            if (rdy) acc_edge = cyc;
            n++;
        end
        TRI_VALID = 1'b0;
        if (acc_edge < 0) chk("push_timeout", 144'd1, 144'd0);
    endtask

    task automatic pulse_done();
        DONE = 1'b1;
        cycles(1);
        DONE = 1'b0;
    endtask

    // Compare the single pending frame with the expected triangle and start edge
    task automatic expect_frame(input string tag, input logic [143:0] t, input int rise);
        chk({tag, "_nframes"}, 144'(rx_bits_q.size()), 144'd1);
        if (rx_bits_q.size() != 0) begin
            chk({tag, "_bits"}, rx_bits_q.pop_front(), t);
            chk({tag, "_len"},  144'(rx_len_q.pop_front()), 144'd144);
            chk({tag, "_rise"}, 144'(rx_rise_q.pop_front()), 144'(rise));
        end
    endtask

    initial begin
        logic [143:0] v0, t1, t2, t3, t4, t5, t6, t7;
        int k, k2, k3, exp_cnt;
        exp_cnt = 0;
        v0 = 144'h0040_0080_FFFF_0100_0080_FFFF_00C0_0100_FFFF;
        t1 = rand_tri(); t2 = rand_tri(); t3 = rand_tri(); t4 = rand_tri();
        t5 = rand_tri(); t6 = rand_tri(); t7 = rand_tri();

        // Reset state
        cycles(3);
        chk("rst_d", 144'(D), 144'd0);
        chk("rst_frame", 144'(D_FRAME), 144'd0);
        chk("rst_busy", 144'(BUSY), 144'd0);
        chk("rst_count", 144'(TRI_COUNT), 144'd0);
        chk("rst_timeout", 144'(TIMEOUT), 144'd0);
        chk("rst_ready", 144'(TRI_READY), 144'd0);
        RST = 1'b0;
        cycles(1);
        chk("post_rst_ready", 144'(TRI_READY), 144'd1);

        // Known vector: frame one edge after push, MSB-first, then wait for DONE
        push(v0, k);
        cycles(150);
        expect_frame("v0", v0, k + 1);
        chk("v0_wait_frame", 144'(D_FRAME), 144'd0);
        chk("v0_wait_d", 144'(D), 144'd0);
        chk("v0_wait_busy", 144'(BUSY), 144'd1);
        cycles(50);
        chk("v0_no_second", 144'(rx_bits_q.size()), 144'd0);
        chk("v0_cnt_before", 144'(TRI_COUNT), 144'(exp_cnt));
        pulse_done();
        exp_cnt++;
        chk("v0_cnt_after", 144'(TRI_COUNT), 144'(exp_cnt));
        chk("v0_busy_after", 144'(BUSY), 144'd0);

        // Three back-to-back pushes with DONE held low
        push(t1, k);
        push(t2, k2);
        push(t3, k3);
        chk("b2b_acc2", 144'(k2), 144'(k + 1));
        chk("b2b_acc3", 144'(k3), 144'(k + 2));
        chk("b2b_full", 144'(TRI_READY), 144'd0);
        cycles(150);
        expect_frame("t1", t1, k + 1);
        chk("t1_still_full", 144'(TRI_READY), 144'd0);
        pulse_done();
        exp_cnt++;
        k = cyc;
        cycles(150);
        expect_frame("t2", t2, k + 1);
        chk("t2_ready", 144'(TRI_READY), 144'd1);
        pulse_done();
        exp_cnt++;
        k = cyc;
        cycles(150);
        expect_frame("t3", t3, k + 1);
        pulse_done();
        exp_cnt++;
        chk("b2b_count", 144'(TRI_COUNT), 144'(exp_cnt));
        chk("b2b_idle_busy", 144'(BUSY), 144'd0);

        // DONE while IDLE and while bit 70 is on D is ignored
        pulse_done();
        chk("idle_done_cnt", 144'(TRI_COUNT), 144'(exp_cnt));
        push(t4, k);
        cycles(74);
        chk("bit70_frame", 144'(D_FRAME), 144'd1);
        chk("bit70_d", 144'(D), 144'(t4[70]));
        pulse_done();
        cycles(80);
        expect_frame("t4", t4, k + 1);
        chk("t4_cnt_unchanged", 144'(TRI_COUNT), 144'(exp_cnt));
        chk("t4_still_waiting", 144'(BUSY), 144'd1);
        pulse_done();
        exp_cnt++;
        chk("t4_cnt_after", 144'(TRI_COUNT), 144'(exp_cnt));

        // Reset at bit 100 with one triangle queued
        push(t5, k);
        push(t6, k2);
        cycles(43);
        chk("pre_rst_d", 144'(D), 144'(t5[100]));
        RST = 1'b1;
        cycles(1);
        chk("midrst_d", 144'(D), 144'd0);
        chk("midrst_frame", 144'(D_FRAME), 144'd0);
        chk("midrst_ready", 144'(TRI_READY), 144'd0);
        RST = 1'b0;
        exp_cnt = 0;
        cycles(200);
        chk("trunc_nframes", 144'(rx_bits_q.size()), 144'd1);
        if (rx_bits_q.size() != 0) begin
            chk("trunc_len", 144'(rx_len_q.pop_front()), 144'd44);
            chk("trunc_bits", rx_bits_q.pop_front(), 144'(t5[143:100]));
            void'(rx_rise_q.pop_front());
        end
        chk("postrst_count", 144'(TRI_COUNT), 144'(exp_cnt));
        chk("postrst_busy", 144'(BUSY), 144'd0);
        chk("postrst_ready", 144'(TRI_READY), 144'd1);
        push(t7, k);
        cycles(150);
        expect_frame("t7", t7, k + 1);
        pulse_done();
        exp_cnt++;
        chk("t7_count", 144'(TRI_COUNT), 144'(exp_cnt));

        // Global properties
        chk("timeout_low", 144'(TIMEOUT), 144'd0);
        chk("d_zero_when_idle", 144'(idle_d_bad), 144'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
